// File: rtl/bp_me_clint_pkg.sv
`default_nettype none
// ============================================================================
// bp_me_clint_pkg : BedRock header types, CLINT register map and FSM states
// Revision: 1.0
// ============================================================================
package bp_me_clint_pkg;

   typedef enum logic [3:0] {
      e_bp_default_cfg = 4'd0
   } bp_params_e;

   localparam int unsigned paddr_width_gp     = 40;
   localparam int unsigned clint_reg_width_gp = 64;

   function automatic int unsigned bp_paddr_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return paddr_width_gp;
         default:          return paddr_width_gp;
      endcase
   endfunction

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [7:0]                payload;
      bp_bedrock_msg_size_e      size;
      logic [paddr_width_gp-1:0] addr;
      logic [3:0]                subop;
      bp_bedrock_mem_type_e      msg_type;
   } bp_bedrock_mem_header_s;

   localparam logic [15:0] clint_msip_offset_gp     = 16'h0000;
   localparam logic [15:0] clint_mtimecmp_offset_gp = 16'h4000;
   localparam logic [15:0] clint_mtime_offset_gp    = 16'hbff8;

   localparam logic [63:0] clint_mtimecmp_reset_gp  = 64'hffff_ffff_ffff_ffff;

   typedef enum logic [0:0] {
      e_ready = 1'b0,
      e_resp  = 1'b1
   } bp_clint_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_me_clint_timer.sv
`default_nettype none
// ============================================================================
// bp_me_clint_timer : mtime / mtimecmp registers and registered timer interrupt
// Revision: 1.0
// ============================================================================
module bp_me_clint_timer
   import bp_me_clint_pkg::*;
  (input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          rtc_tick_i,
   input  logic                          mtime_w_v_i,
   input  logic                          mtimecmp_w_v_i,
   input  logic [clint_reg_width_gp-1:0] w_data_i,
   input  logic [clint_reg_width_gp-1:0] w_mask_i,
   output logic [clint_reg_width_gp-1:0] mtime_o,
   output logic [clint_reg_width_gp-1:0] mtimecmp_o,
   output logic                          timer_irq_o);

   logic [clint_reg_width_gp-1:0] mtime_q, mtime_d;
   logic [clint_reg_width_gp-1:0] mtimecmp_q, mtimecmp_d;
   logic                          timer_irq_q, timer_irq_d;

   // A write fully overrides a coincident tick; masked halves keep their old bits.
   always_comb begin
      mtime_d     = mtime_q;
      mtimecmp_d  = mtimecmp_q;
      timer_irq_d = (mtime_q >= mtimecmp_q);
      if (mtime_w_v_i) begin
         mtime_d = (mtime_q & ~w_mask_i) | (w_data_i & w_mask_i);
      end else if (rtc_tick_i) begin
         mtime_d = mtime_q + 64'd1;
      end
      if (mtimecmp_w_v_i) begin
         mtimecmp_d = (mtimecmp_q & ~w_mask_i) | (w_data_i & w_mask_i);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mtime_q     <= '0;
         mtimecmp_q  <= clint_mtimecmp_reset_gp;
         timer_irq_q <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   assign mtime_o     = mtime_q;
   assign mtimecmp_o  = mtimecmp_q;
   assign timer_irq_o = timer_irq_q;

endmodule
`default_nettype wire

// File: rtl/bp_me_clint_responder.sv
`default_nettype none
// ============================================================================
// bp_me_clint_responder : BedRock memory-command endpoint for the CLINT registers
// Revision: 1.0
// ============================================================================
module bp_me_clint_responder
   import bp_me_clint_pkg::*;
 #(parameter bp_params_e  bp_params_p  = e_bp_default_cfg,
   parameter int unsigned data_width_p = 64)
  (input  logic                   clk_i,
   input  logic                   reset_i,
   input  bp_bedrock_mem_header_s mem_cmd_header_i,
   input  logic [data_width_p-1:0] mem_cmd_data_i,
   input  logic                   mem_cmd_v_i,
   output logic                   mem_cmd_ready_and_o,
   output bp_bedrock_mem_header_s mem_resp_header_o,
   output logic [data_width_p-1:0] mem_resp_data_o,
   output logic                   mem_resp_v_o,
   input  logic                   mem_resp_ready_and_i,
   input  logic                   rtc_tick_i,
   output logic                   timer_irq_o,
   output logic                   software_irq_o);

   localparam int unsigned paddr_width_lp  = bp_paddr_width(bp_params_p);
   localparam int unsigned offset_width_lp = (paddr_width_lp < 16) ? paddr_width_lp : 16;

   bp_clint_state_e        state_q, state_d;
   bp_bedrock_mem_header_s resp_header_q, resp_header_d;
   logic [data_width_p-1:0] resp_data_q, resp_data_d;
   logic                   msip_q, msip_d;

   logic [15:0] offset;
   logic        msip_hit, mtimecmp_hit, mtime_hit;
   logic        is_rd, is_wr, half, hi_sel, cmd_fire;
   logic [63:0] wr_data, wr_mask, reg_full, rd_data;
   logic [31:0] reg_lo, reg_hi, rd_word;
   logic [63:0] mtime, mtimecmp;

   assign offset = 16'(mem_cmd_header_i.addr[offset_width_lp-1:0]);

   // Registers are decoded on the 8-byte word so 4B accesses to either half hit.
   assign msip_hit     = (offset[15:3] == clint_msip_offset_gp[15:3]);
   assign mtimecmp_hit = (offset[15:3] == clint_mtimecmp_offset_gp[15:3]);
   assign mtime_hit    = (offset[15:3] == clint_mtime_offset_gp[15:3]);

   assign is_rd  = (mem_cmd_header_i.msg_type == e_bedrock_mem_rd)
                 | (mem_cmd_header_i.msg_type == e_bedrock_mem_uc_rd);
   assign is_wr  = (mem_cmd_header_i.msg_type == e_bedrock_mem_wr)
                 | (mem_cmd_header_i.msg_type == e_bedrock_mem_uc_wr);
   assign half   = (mem_cmd_header_i.size < e_bedrock_msg_size_8);
   assign hi_sel = offset[2];

   assign cmd_fire = mem_cmd_v_i & (state_q == e_ready);

   always_comb begin
      wr_data = mem_cmd_data_i;
      wr_mask = '1;
      if (half) begin
         wr_data = {2{mem_cmd_data_i[31:0]}};
         wr_mask = hi_sel ? {32'hffff_ffff, 32'h0} : {32'h0, 32'hffff_ffff};
      end
   end

   // msip is bit 0 of whichever word is addressed, so its high word mirrors the low one.
   always_comb begin
      reg_full = '0;
      if (msip_hit)          reg_full = {63'b0, msip_q};
      else if (mtimecmp_hit) reg_full = mtimecmp;
      else if (mtime_hit)    reg_full = mtime;
      reg_lo  = reg_full[31:0];
      reg_hi  = msip_hit ? {31'b0, msip_q} : reg_full[63:32];
      rd_word = hi_sel ? reg_hi : reg_lo;
      rd_data = half ? {2{rd_word}} : reg_full;
   end

   always_comb begin
      state_d             = state_q;
      resp_header_d       = resp_header_q;
      resp_data_d         = resp_data_q;
      msip_d              = msip_q;
      mem_cmd_ready_and_o = 1'b0;
      mem_resp_v_o        = 1'b0;
      case (state_q)
         e_ready: begin
            mem_cmd_ready_and_o = 1'b1;
            if (cmd_fire) begin
               resp_header_d = mem_cmd_header_i;
               resp_data_d   = is_rd ? rd_data : '0;
               if (is_wr && msip_hit) msip_d = mem_cmd_data_i[0];
               state_d       = e_resp;
            end
         end
         e_resp: begin
            mem_resp_v_o = 1'b1;
            if (mem_resp_ready_and_i) state_d = e_ready;
         end
         default: state_d = e_ready;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= e_ready;
         resp_header_q <= '0;
         resp_data_q   <= '0;
         msip_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         resp_header_q <= resp_header_d;
         resp_data_q   <= resp_data_d;
         msip_q        <= msip_d;
      end
   end

   bp_me_clint_timer u_timer
     (.clk_i          (clk_i),
      .reset_i        (reset_i),
      .rtc_tick_i     (rtc_tick_i),
      .mtime_w_v_i    (cmd_fire & is_wr & mtime_hit),
      .mtimecmp_w_v_i (cmd_fire & is_wr & mtimecmp_hit),
      .w_data_i       (wr_data),
      .w_mask_i       (wr_mask),
      .mtime_o        (mtime),
      .mtimecmp_o     (mtimecmp),
      .timer_irq_o    (timer_irq_o));

   assign mem_resp_header_o = resp_header_q;
   assign mem_resp_data_o   = resp_data_q;
   assign software_irq_o    = msip_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_me_clint_responder.sv
`default_nettype none
// ============================================================================
// tb_bp_me_clint_responder : directed plan plus randomized traffic vs. a CLINT model
// Revision: 1.0
// ============================================================================
module tb_bp_me_clint_responder;
   import bp_me_clint_pkg::*;

   logic                   clk_i = 1'b0;
   logic                   reset_i = 1'b1;
   bp_bedrock_mem_header_s mem_cmd_header_i = '0;
   logic [63:0]            mem_cmd_data_i = '0;
   logic                   mem_cmd_v_i = 1'b0;
   logic                   mem_cmd_ready_and_o;
   bp_bedrock_mem_header_s mem_resp_header_o;
   logic [63:0]            mem_resp_data_o;
   logic                   mem_resp_v_o;
   logic                   mem_resp_ready_and_i = 1'b0;
   logic                   rtc_tick_i = 1'b0;
   logic                   timer_irq_o;
   logic                   software_irq_o;

   bp_me_clint_responder #(.bp_params_p(e_bp_default_cfg), .data_width_p(64)) dut
     (.clk_i                (clk_i),
      .reset_i              (reset_i),
      .mem_cmd_header_i     (mem_cmd_header_i),
      .mem_cmd_data_i       (mem_cmd_data_i),
      .mem_cmd_v_i          (mem_cmd_v_i),
      .mem_cmd_ready_and_o  (mem_cmd_ready_and_o),
      .mem_resp_header_o    (mem_resp_header_o),
      .mem_resp_data_o      (mem_resp_data_o),
      .mem_resp_v_o         (mem_resp_v_o),
      .mem_resp_ready_and_i (mem_resp_ready_and_i),
      .rtc_tick_i           (rtc_tick_i),
      .timer_irq_o          (timer_irq_o),
      .software_irq_o       (software_irq_o));

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Architectural model of the CLINT: plain registers, updated once per clock.
   logic [63:0] m_mtime = 64'd0;
   logic [63:0] m_cmp   = 64'hffff_ffff_ffff_ffff;
   logic        m_msip  = 1'b0;
   logic        m_irq   = 1'b0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic rand_pct(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic hi,
                                         input logic full, input logic [63:0] wd);
      if (full) return wd;
      return hi ? {wd[31:0], old[31:0]} : {old[63:32], wd[31:0]};
   endfunction

   function automatic logic [63:0] model_read(input logic [15:0] off, input logic full);
      logic [63:0] v;
      logic [31:0] w;
      logic [15:0] base;
      base = off & 16'hfff8;
      if (base == 16'h0000)      v = {63'b0, m_msip};
      else if (base == 16'h4000) v = m_cmp;
      else if (base == 16'hbff8) v = m_mtime;
      else                       v = 64'd0;
      if (full) return v;
      if (base == 16'h0000) w = {31'b0, m_msip};
      else                  w = off[2] ? v[63:32] : v[31:0];
      return {w, w};
   endfunction

   task automatic step(input logic wr, input logic [15:0] off, input logic full, input logic [63:0] wd);
      logic        irq_next;
      logic [15:0] base;
      @(posedge clk_i);
      irq_next = (m_mtime >= m_cmp);
      base     = off & 16'hfff8;
      if (rtc_tick_i && !(wr && base == 16'hbff8)) m_mtime = m_mtime + 64'd1;
      if (wr) begin
         if (base == 16'h0000)      m_msip  = wd[0];
         else if (base == 16'h4000) m_cmp   = merge(m_cmp, off[2], full, wd);
         else if (base == 16'hbff8) m_mtime = merge(m_mtime, off[2], full, wd);
      end
      m_irq = irq_next;
      #1;
      check_value("timer_irq", 64'(timer_irq_o), 64'(m_irq));
      check_value("software_irq", 64'(software_irq_o), 64'(m_msip));
   endtask

   task automatic idle(input int n, input int tick_pct);
      for (int i = 0; i < n; i++) begin
         mem_cmd_v_i = 1'b0;
         rtc_tick_i  = rand_pct(tick_pct);
         step(1'b0, 16'h0, 1'b0, 64'h0);
      end
      rtc_tick_i = 1'b0;
   endtask

   task automatic model_reset();
      m_mtime = 64'd0;
      m_cmp   = 64'hffff_ffff_ffff_ffff;
      m_msip  = 1'b0;
      m_irq   = 1'b0;
   endtask

   // One full command/response transaction; optionally resets while the response is pending.
   task automatic issue(input bp_bedrock_mem_type_e mt, input logic [39:0] addr,
                        input bp_bedrock_msg_size_e sz, input logic [63:0] wd,
                        input int stall, input int accept_tick_pct, input int stall_tick_pct,
                        input logic reset_in_resp, output logic [63:0] rdata);
      bp_bedrock_mem_header_s h, g;
      logic [63:0] exp_data;
      logic        is_rd, is_wr, full;
      logic [15:0] off;
      h          = '0;
      h.msg_type = mt;
      h.addr     = addr;
      h.size     = sz;
      h.subop    = 4'($urandom);
      h.payload  = 8'($urandom);
      off   = addr[15:0];
      full  = (sz == e_bedrock_msg_size_8);
      is_rd = (mt == e_bedrock_mem_rd) || (mt == e_bedrock_mem_uc_rd);
      is_wr = (mt == e_bedrock_mem_wr) || (mt == e_bedrock_mem_uc_wr);
      exp_data = is_rd ? model_read(off, full) : 64'd0;

      check_value("cmd_ready_idle", 64'(mem_cmd_ready_and_o), 64'd1);
      mem_cmd_header_i     = h;
      mem_cmd_data_i       = wd;
      mem_cmd_v_i          = 1'b1;
      mem_resp_ready_and_i = 1'b0;
      rtc_tick_i           = rand_pct(accept_tick_pct);
      step(is_wr, off, full, wd);
      check_value("resp_v", 64'(mem_resp_v_o), 64'd1);
      check_value("resp_header", {5'b0, mem_resp_header_o}, {5'b0, h});
      check_value("resp_data", mem_resp_data_o, exp_data);
      check_value("cmd_ready_busy", 64'(mem_cmd_ready_and_o), 64'd0);
      rdata = mem_resp_data_o;

      if (reset_in_resp) begin
         #1;
         reset_i = 1'b1;
         #1;
         model_reset();
         check_value("reset_resp_v", 64'(mem_resp_v_o), 64'd0);
         check_value("reset_resp_data", mem_resp_data_o, 64'd0);
         check_value("reset_resp_header", {5'b0, mem_resp_header_o}, 64'd0);
         check_value("reset_sw_irq", 64'(software_irq_o), 64'd0);
         check_value("reset_cmd_ready", 64'(mem_cmd_ready_and_o), 64'd1);
         mem_cmd_v_i = 1'b0;
         rtc_tick_i  = 1'b0;
         @(posedge clk_i);
         #1;
         reset_i = 1'b0;
         return;
      end

      // A competing mtime write is held valid while busy; it must never be taken.
      for (int i = 0; i <= stall; i++) begin
         g          = '0;
         g.msg_type = e_bedrock_mem_uc_wr;
         g.addr     = 40'h00_0000_bff8;
         g.size     = e_bedrock_msg_size_8;
         mem_cmd_header_i     = g;
         mem_cmd_data_i       = {$urandom, $urandom};
         mem_cmd_v_i          = 1'b1;
         mem_resp_ready_and_i = (i == stall);
         rtc_tick_i           = rand_pct(stall_tick_pct);
         step(1'b0, 16'h0, 1'b0, 64'h0);
         if (i < stall) begin
            check_value("stall_resp_v", 64'(mem_resp_v_o), 64'd1);
            check_value("stall_header", {5'b0, mem_resp_header_o}, {5'b0, h});
            check_value("stall_data", mem_resp_data_o, exp_data);
            check_value("stall_cmd_ready", 64'(mem_cmd_ready_and_o), 64'd0);
         end else begin
            check_value("done_resp_v", 64'(mem_resp_v_o), 64'd0);
            check_value("done_cmd_ready", 64'(mem_cmd_ready_and_o), 64'd1);
         end
      end
      mem_cmd_v_i          = 1'b0;
      mem_resp_ready_and_i = 1'b0;
      rtc_tick_i           = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic [15:0] offs [8];
      logic [15:0] off;
      logic [63:0] wd;
      bp_bedrock_mem_type_e mt;
      bp_bedrock_msg_size_e sz;

      offs = '{16'h0000, 16'h0004, 16'h4000, 16'h4004, 16'hbff8, 16'hbffc, 16'h1230, 16'hbff0};

      repeat (2) @(posedge clk_i);
      #1;
      check_value("rst_resp_v", 64'(mem_resp_v_o), 64'd0);
      check_value("rst_resp_header", {5'b0, mem_resp_header_o}, 64'd0);
      check_value("rst_resp_data", mem_resp_data_o, 64'd0);
      check_value("rst_cmd_ready", 64'(mem_cmd_ready_and_o), 64'd1);
      check_value("rst_timer_irq", 64'(timer_irq_o), 64'd0);
      check_value("rst_sw_irq", 64'(software_irq_o), 64'd0);
      reset_i = 1'b0;

      // Read mtime straight out of reset.
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_bff8, e_bedrock_msg_size_8, 64'h0, 0, 0, 0, 1'b0, rd);
      check_value("mtime_after_reset", rd, 64'd0);

      // Timer compare at 0x10, then walk mtime up with single-cycle pulses.
      issue(e_bedrock_mem_uc_wr, 40'h00_0000_4000, e_bedrock_msg_size_8, 64'h10, 0, 0, 0, 1'b0, rd);
      for (int i = 0; i < 16; i++) begin
         idle(1, 100);
         idle(1, 0);
      end
      check_value("irq_after_16_ticks", 64'(timer_irq_o), 64'd1);
      issue(e_bedrock_mem_uc_wr, 40'h00_0000_4000, e_bedrock_msg_size_8, 64'h20, 0, 0, 0, 1'b0, rd);
      idle(1, 0);
      check_value("irq_cleared", 64'(timer_irq_o), 64'd0);

      // Backpressured read followed by an immediate next command.
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_4000, e_bedrock_msg_size_8, 64'h0, 5, 0, 0, 1'b0, rd);
      check_value("stalled_read", rd, 64'h20);
      issue(e_bedrock_mem_rd, 40'h00_0000_bff8, e_bedrock_msg_size_8, 64'h0, 0, 0, 0, 1'b0, rd);
      check_value("mtime_16", rd, 64'h10);

      // Upper-half write, then 4B read replicating the half.
      issue(e_bedrock_mem_uc_wr, 40'h00_0000_bffc, e_bedrock_msg_size_4, 64'h1111_2222_dead_beef, 0, 0, 0, 1'b0, rd);
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_bffc, e_bedrock_msg_size_4, 64'h0, 0, 0, 0, 1'b0, rd);
      check_value("mtime_hi_replicated", rd, 64'hdead_beef_dead_beef);
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_bff8, e_bedrock_msg_size_8, 64'h0, 0, 0, 0, 1'b0, rd);
      check_value("mtime_hi_write", rd, 64'hdead_beef_0000_0010);

      // Wrap at 2^64 and write/tick collision.
      issue(e_bedrock_mem_uc_wr, 40'h00_0000_bff8, e_bedrock_msg_size_8, 64'hffff_ffff_ffff_ffff, 0, 0, 0, 1'b0, rd);
      idle(1, 100);
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_bff8, e_bedrock_msg_size_8, 64'h0, 0, 0, 0, 1'b0, rd);
      check_value("mtime_wrap", rd, 64'd0);
      issue(e_bedrock_mem_uc_wr, 40'h00_0000_bff8, e_bedrock_msg_size_8, 64'h1234, 0, 100, 0, 1'b0, rd);
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_bff8, e_bedrock_msg_size_8, 64'h0, 0, 0, 0, 1'b0, rd);
      check_value("write_beats_tick", rd, 64'h1234);

      // Software interrupt, then reset during a pending response.
      issue(e_bedrock_mem_uc_wr, 40'h00_0000_0000, e_bedrock_msg_size_8, 64'h1, 0, 0, 0, 1'b0, rd);
      check_value("msip_set", 64'(software_irq_o), 64'd1);
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_0000, e_bedrock_msg_size_8, 64'h0, 0, 0, 0, 1'b1, rd);
      check_value("msip_read_before_reset", rd, 64'd1);
      idle(2, 0);
      issue(e_bedrock_mem_uc_rd, 40'h00_0000_4000, e_bedrock_msg_size_8, 64'h0, 0, 0, 0, 1'b0, rd);
      check_value("mtimecmp_after_reset", rd, 64'hffff_ffff_ffff_ffff);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         off = offs[$urandom_range(7)];
         if ($urandom_range(7) == 0) off = 16'($urandom);
         mt = bp_bedrock_mem_type_e'($urandom_range(5));
         sz = bp_bedrock_msg_size_e'($urandom_range(3));
         wd = {$urandom, $urandom};
         if ((off & 16'hfff8) == 16'h4000 && $urandom_range(1) == 1)
            wd = m_mtime + 64'($urandom_range(8)) - 64'd4;
         issue(mt, {24'($urandom), off}, sz, wd, $urandom_range(3), 50, 50, 1'b0, rd);
         if ($urandom_range(3) == 0) idle($urandom_range(1, 4), 60);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
